inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
Front-end fetch stage. It holds the PC, requests one instruction at a time from the instruction cache, predicts the next PC, and pushes {inst, pc, prediction} into the instruction queue. It is redirected by the reorder buffer on rollback. Its 2-bit branch history table is trained by committed branches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset
BHT_IDX_W, 6, log2 of BHT entries (64); index = pc[BHT_IDX_W+1:2]

Ports:
clk  in  1  clock
rst  in  1  reset, active-low, asynchronous
rdy  in  1  global enable; low freezes the block
IQ_is_full  in  1  queue cannot accept a new request's result
IQ_input_valid  out  1  one-cycle push strobe to the queue
IQ_inst  out  32  fetched instruction
IQ_inst_pc  out  32  its PC
IQ_predicted_to_jump  out  1  prediction taken
IQ_predicted_pc  out  32  predicted next PC
IC_req_valid  out  1  fetch request, held until response
IC_req_addr  out  32  fetch address, stable while IC_req_valid is high
IC_resp_valid  in  1  one-cycle response strobe
IC_resp_inst  in  32  instruction data
ROB_roll_back_flag  in  1  redirect
ROB_target_pc  in  32  redirect PC
ROB_br_update_valid  in  1  committed conditional branch
ROB_br_pc  in  32  its PC
ROB_br_taken  in  1  actual outcome

Behaviour:
- Reset (rst=0, async):
  - state=S_IDLE, pc=RESET_PC.
  - All outputs 0.
  - All BHT counters = 2'b01 (weakly not-taken).
- rdy=0: all state, the PC and the BHT hold; IQ_input_valid forced 0. The cache shares rdy, so no response arrives while rdy=0.
- States:
  - S_IDLE: if !IQ_is_full, assert IC_req_valid=1 and IC_req_addr=pc, then go to S_WAIT. Otherwise hold IC_req_valid=0.
  - S_WAIT: IC_req_valid stays 1. On IC_resp_valid:
    - IQ_input_valid<=1 for one cycle, IQ_inst<=IC_resp_inst, IQ_inst_pc<=pc, plus the prediction.
    - pc<=predicted pc; IC_req_valid<=0; go to S_IDLE.
  - S_FLUSH: a stale request is outstanding. IC_req_valid and IC_req_addr are held. On IC_resp_valid the data is discarded, IC_req_valid<=0, go to S_IDLE.
- Throughput: one instruction per (cache latency + 2) cycles. A new request issues in the cycle after the push.
- IQ_is_full is sampled only at issue. A response that returns after the queue fills is still pushed; the queue's full flag reserves that slot.
- Prediction, combinational on IC_resp_inst, opcode = inst[6:0]:
  - JAL (1101111): taken; target = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - BRANCH (1100011): taken iff BHT[pc idx][1]; target = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - All others, including JALR: not taken, next = pc+4.
  - All adds are 32-bit wrapping.
- Rollback (ROB_roll_back_flag=1) has highest priority, even over a same-cycle response:
  - pc<=ROB_target_pc; IQ_input_valid<=0.
  - From S_WAIT with IC_resp_valid=0: go to S_FLUSH.
  - From S_WAIT with IC_resp_valid=1: drop the data, go to S_IDLE.
  - From S_FLUSH: stay in S_FLUSH; if IC_resp_valid=1, go to S_IDLE.
  - From S_IDLE: stay in S_IDLE and issue no request that cycle.
- BHT update: on ROB_br_update_valid, the 2-bit saturating counter at ROB_br_pc index counts +1 if taken, -1 if not, clamped at 0 and 3.
  - A same-cycle lookup at the same index reads the old value.
  - Updates proceed in every state, including during rollback.
- Reset mid-request: the block returns to S_IDLE with IC_req_valid=0. The cache is reset by the same rst.

Decomposition:
- Shared defines file: AddrWidth/InstWidth (32), OPCODE_JAL, OPCODE_BR, True/False, state encodings.
- One sub-module, branch_predictor: the BHT array, combinational lookup port, synchronous update port.
- Immediate extraction and FSM stay in inst_fetcher.

Test Plan:
- Reset then release, 1-cycle-latency cache, addi stream: pushes at pc 0x0, 0x4, 0x8, predicted_pc=pc+4, taken=0.
- JAL at 0x10 with imm=+0x20: push taken=1, predicted_pc=0x30; next IC_req_addr=0x30.
- BEQ at 0x40 with imm=-8: initially not taken, next pc 0x44. Apply two taken updates at 0x40, refetch: taken=1, predicted_pc=0x38. Three more updates saturate the counter at 3.
- Rollback with target 0x100 while in S_WAIT, response 3 cycles later: no push of the stale data, then request at 0x100.
- Rollback coincident with IC_resp_valid: no push; next request at the target in the following IDLE cycle.
- IQ_is_full=1 for 5 cycles in S_IDLE: IC_req_valid stays 0. Release the flag: request issues the next cycle. rdy=0 mid-S_WAIT: no push and state held.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage: widths, opcodes,
// FSM encoding, queue payload and immediate decoders.
package inst_fetcher_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned InstWidth   = 32;
  localparam int unsigned OpcodeWidth = 7;

  localparam logic [OpcodeWidth-1:0] OPCODE_JAL = 7'b1101111;
  localparam logic [OpcodeWidth-1:0] OPCODE_BR  = 7'b1100011;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [1:0] BHT_MIN     = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT = 2'b01;
  localparam logic [1:0] BHT_MAX     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [InstWidth-1:0] inst;
    logic [AddrWidth-1:0] pc;
    logic                 taken;
    logic [AddrWidth-1:0] pred_pc;
  } iq_entry_t;

  function automatic logic [AddrWidth-1:0] jal_offset(input logic [InstWidth-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [AddrWidth-1:0] br_offset(input logic [InstWidth-1:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bundle of queue, cache and reorder-buffer signals seen by the fetch stage.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic                 IQ_is_full;
  logic                 IQ_input_valid;
  logic [InstWidth-1:0] IQ_inst;
  logic [AddrWidth-1:0] IQ_inst_pc;
  logic                 IQ_predicted_to_jump;
  logic [AddrWidth-1:0] IQ_predicted_pc;
  logic                 IC_req_valid;
  logic [AddrWidth-1:0] IC_req_addr;
  logic                 IC_resp_valid;
  logic [InstWidth-1:0] IC_resp_inst;
  logic                 ROB_roll_back_flag;
  logic [AddrWidth-1:0] ROB_target_pc;
  logic                 ROB_br_update_valid;
  logic [AddrWidth-1:0] ROB_br_pc;
  logic                 ROB_br_taken;

  modport master (
    input  IQ_is_full, IC_resp_valid, IC_resp_inst,
           ROB_roll_back_flag, ROB_target_pc,
           ROB_br_update_valid, ROB_br_pc, ROB_br_taken,
    output IQ_input_valid, IQ_inst, IQ_inst_pc, IQ_predicted_to_jump,
           IQ_predicted_pc, IC_req_valid, IC_req_addr
  );

  modport slave (
    output IQ_is_full, IC_resp_valid, IC_resp_inst,
           ROB_roll_back_flag, ROB_target_pc,
           ROB_br_update_valid, ROB_br_pc, ROB_br_taken,
    input  IQ_input_valid, IQ_inst, IQ_inst_pc, IQ_predicted_to_jump,
           IQ_predicted_pc, IC_req_valid, IC_req_addr
  );
endinterface

// File: rtl/inst_fetcher_branch_predictor.sv
// Table of 2-bit saturating branch counters: combinational lookup, synchronous
// training from committed branches. A same-cycle lookup sees the old count.
module inst_fetcher_branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             lookup_taken_c_o,
  input  logic             update_valid_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i
);

  localparam int unsigned Entries = 32'd1 << IDX_W;

  logic [1:0] bht_q [Entries];
  logic [1:0] cur_cnt;
  logic [1:0] upd_cnt_d;

  assign lookup_taken_c_o = bht_q[lookup_idx_i][1];
  assign cur_cnt          = bht_q[update_idx_i];

  // Saturating step toward the observed outcome.
  always_comb begin
    upd_cnt_d = cur_cnt;
    if (update_taken_i && cur_cnt != BHT_MAX) begin
      upd_cnt_d = cur_cnt + 2'd1;
    end else if (!update_taken_i && cur_cnt != BHT_MIN) begin
      upd_cnt_d = cur_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        bht_q[i] <= BHT_WEAK_NT;
      end
    end else if (en_i && update_valid_i) begin
      bht_q[update_idx_i] <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding cache request at a time, next-PC prediction,
// pushes into the instruction queue, redirect on reorder-buffer rollback.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned          BHT_IDX_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  inst_fetcher_if.master bus
);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic                 req_valid_q, req_valid_d;
  logic [AddrWidth-1:0] req_addr_q, req_addr_d;
  logic                 iq_valid_q, iq_valid_d;
  iq_entry_t            iq_q, iq_d;

  logic [OpcodeWidth-1:0] opcode_c;
  logic                   bht_taken_c;
  logic                   pred_taken_c;
  logic [AddrWidth-1:0]   pred_pc_c;
  logic                   unused_br_pc_bits;

  assign unused_br_pc_bits = ^{bus.ROB_br_pc[AddrWidth-1:BHT_IDX_W+2], bus.ROB_br_pc[1:0]};

  inst_fetcher_branch_predictor #(.IDX_W(BHT_IDX_W)) u_bp (
    .clk              (clk),
    .rst              (rst),
    .en_i             (rdy),
    .lookup_idx_i     (pc_q[BHT_IDX_W+1:2]),
    .lookup_taken_c_o (bht_taken_c),
    .update_valid_i   (bus.ROB_br_update_valid),
    .update_idx_i     (bus.ROB_br_pc[BHT_IDX_W+1:2]),
    .update_taken_i   (bus.ROB_br_taken)
  );

  // Next-PC prediction for the instruction returning this cycle.
  assign opcode_c = bus.IC_resp_inst[OpcodeWidth-1:0];

  always_comb begin
    pred_taken_c = False;
    pred_pc_c    = pc_q + AddrWidth'(4);
    if (opcode_c == OPCODE_JAL) begin
      pred_taken_c = True;
      pred_pc_c    = pc_q + jal_offset(bus.IC_resp_inst);
    end else if (opcode_c == OPCODE_BR && bht_taken_c) begin
      pred_taken_c = True;
      pred_pc_c    = pc_q + br_offset(bus.IC_resp_inst);
    end
  end

  // Next state; a rollback overrides any same-cycle response.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    iq_valid_d  = False;
    iq_d        = iq_q;
    if (bus.ROB_roll_back_flag) begin
      pc_d = bus.ROB_target_pc;
      case (state_q)
        S_WAIT, S_FLUSH: begin
          if (bus.IC_resp_valid) begin
            req_valid_d = False;
            state_d     = S_IDLE;
          end else begin
            state_d = S_FLUSH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.IQ_is_full) begin
            req_valid_d = True;
            req_addr_d  = pc_q;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.IC_resp_valid) begin
            iq_valid_d   = True;
            iq_d.inst    = bus.IC_resp_inst;
            iq_d.pc      = pc_q;
            iq_d.taken   = pred_taken_c;
            iq_d.pred_pc = pred_pc_c;
            pc_d         = pred_pc_c;
            req_valid_d  = False;
            state_d      = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (bus.IC_resp_valid) begin
            req_valid_d = False;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= False;
      req_addr_q  <= '0;
      iq_valid_q  <= False;
      iq_q        <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      iq_valid_q  <= iq_valid_d;
      iq_q        <= iq_d;
    end else begin
      iq_valid_q  <= False;
    end
  end

  assign bus.IQ_input_valid       = iq_valid_q;
  assign bus.IQ_inst              = iq_q.inst;
  assign bus.IQ_inst_pc           = iq_q.pc;
  assign bus.IQ_predicted_to_jump = iq_q.taken;
  assign bus.IQ_predicted_pc      = iq_q.pred_pc;
  assign bus.IC_req_valid         = req_valid_q;
  assign bus.IC_req_addr          = req_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: latency-programmable cache model, reference fetch
// model checked every cycle, and directed scenarios with literal expectations.
module tb_inst_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  inst_fetcher_if bus ();

  inst_fetcher #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endfunction

  // Instruction memory; unlisted addresses hold addi x0,x0,0.
  logic [31:0] imem [logic [31:0]];
  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0000_0013;
  endfunction

  // Cache: response strobe lands 'lat' cycles after the request first shows.
  int          lat = 1;
  bit          c_pending = 0;
  int          c_left = 0;
  logic [31:0] c_addr = '0;
  initial begin
    bus.IC_resp_valid = 1'b0;
    bus.IC_resp_inst  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.IC_resp_valid) begin
        bus.IC_resp_valid = 1'b0;
        c_pending = 0;
      end else if (c_pending && c_left == 0) begin
        bus.IC_resp_valid = 1'b1;
        bus.IC_resp_inst  = imem_rd(c_addr);
      end
      @(negedge clk);
      if (!rst) begin
        c_pending = 0;
        bus.IC_resp_valid = 1'b0;
      end else if (!c_pending) begin
        if (rdy && bus.IC_req_valid) begin
          c_pending = 1;
          c_left    = lat - 1;
          c_addr    = bus.IC_req_addr;
        end
      end else if (!bus.IC_resp_valid && rdy && c_left > 0) begin
        c_left--;
      end
    end
  end

  // Reference model: next fetch address, outstanding request, counters.
  int          bhtm [64];
  logic [31:0] m_next_pc, m_req_pc;
  bit          m_out, m_stale, m_after_resp;
  bit          e_valid, e_taken;
  logic [31:0] e_inst, e_pc, e_pred;

  function automatic void model_reset();
    foreach (bhtm[i]) bhtm[i] = 1;
    m_next_pc = 32'h0; m_req_pc = 32'h0;
    m_out = 0; m_stale = 0; m_after_resp = 0; e_valid = 0;
  endfunction

  function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                  output bit tk, output logic [31:0] nx);
    int off;
    logic [6:0] op;
    op = inst[6:0];
    tk = 0;
    nx = pc + 32'd4;
    if (op == 7'h6F) begin
      off = int'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      if (inst[31]) off -= (1 << 21);
      tk = 1;
      nx = pc + 32'(off);
    end else if (op == 7'h63 && bhtm[pc[7:2]] >= 2) begin
      off = int'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      if (inst[31]) off -= (1 << 13);
      tk = 1;
      nx = pc + 32'(off);
    end
  endfunction

  initial begin
    bit          tk;
    logic [31:0] nx;
    int          ix;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_reset();
      end else begin
        chk("push_valid", 32'(bus.IQ_input_valid), 32'(e_valid));
        if (e_valid && bus.IQ_input_valid) begin
          chk("push_inst", bus.IQ_inst, e_inst);
          chk("push_pc", bus.IQ_inst_pc, e_pc);
          chk("push_taken", 32'(bus.IQ_predicted_to_jump), 32'(e_taken));
          chk("push_pred_pc", bus.IQ_predicted_pc, e_pred);
        end
        if (m_after_resp) begin
          chk("req_drop", 32'(bus.IC_req_valid), 32'd0);
          m_after_resp = 0;
        end else if (m_out) begin
          chk("req_held", 32'(bus.IC_req_valid), 32'd1);
          chk("req_addr_stable", bus.IC_req_addr, m_req_pc);
        end else if (bus.IC_req_valid) begin
          chk("req_addr", bus.IC_req_addr, m_next_pc);
          m_out = 1; m_stale = 0; m_req_pc = m_next_pc;
        end
        e_valid = 0;
        if (rdy) begin
          if (bus.ROB_roll_back_flag) begin
            m_next_pc = bus.ROB_target_pc;
            if (m_out) m_stale = 1;
          end
          if (bus.IC_resp_valid) begin
            if (!m_stale) begin
              predict(bus.IC_resp_inst, m_req_pc, tk, nx);
              e_valid = 1; e_inst = bus.IC_resp_inst; e_pc = m_req_pc;
              e_taken = tk; e_pred = nx; m_next_pc = nx;
            end
            m_out = 0; m_after_resp = 1;
          end
          if (bus.ROB_br_update_valid) begin
            ix = int'(bus.ROB_br_pc[7:2]);
            if (bus.ROB_br_taken) bhtm[ix] = (bhtm[ix] == 3) ? 3 : bhtm[ix] + 1;
            else                  bhtm[ix] = (bhtm[ix] == 0) ? 0 : bhtm[ix] - 1;
          end
        end
      end
    end
  end

  task automatic wait_push(input logic [31:0] pc, output logic [31:0] pred,
                           output logic tk, output int n);
    n = 0; pred = '0; tk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (bus.IQ_input_valid && bus.IQ_inst_pc == pc) begin
        pred = bus.IQ_predicted_pc;
        tk   = bus.IQ_predicted_to_jump;
        return;
      end
    end
    timeout("wait_push");
  endtask

  task automatic wait_any_push(output logic [31:0] pc);
    pc = '1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.IQ_input_valid) begin
        pc = bus.IQ_inst_pc;
        return;
      end
    end
    timeout("wait_any_push");
  endtask

  task automatic wait_req(output logic [31:0] addr);
    logic prev;
    prev = bus.IC_req_valid;
    addr = '1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.IC_req_valid && !prev) begin
        addr = bus.IC_req_addr;
        return;
      end
      prev = bus.IC_req_valid;
    end
    timeout("wait_req");
  endtask

  task automatic bht_update(input logic [31:0] pc, input logic taken);
    @(posedge clk); #1;
    bus.ROB_br_update_valid = 1'b1;
    bus.ROB_br_pc           = pc;
    bus.ROB_br_taken        = taken;
    @(posedge clk); #1;
    bus.ROB_br_update_valid = 1'b0;
  endtask

  task automatic rollback(input logic [31:0] target);
    @(posedge clk); #1;
    bus.ROB_roll_back_flag = 1'b1;
    bus.ROB_target_pc      = target;
    @(posedge clk); #1;
    bus.ROB_roll_back_flag = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pred, a, p;
    logic        tk;
    int          n;
    bus.IQ_is_full          = 1'b0;
    bus.ROB_roll_back_flag  = 1'b0;
    bus.ROB_target_pc       = '0;
    bus.ROB_br_update_valid = 1'b0;
    bus.ROB_br_pc           = '0;
    bus.ROB_br_taken        = 1'b0;
    imem[32'h10] = 32'h0200_006F;   // jal x0, +0x20
    imem[32'h40] = 32'hFE00_0CE3;   // beq x0, x0, -8

    repeat (2) @(negedge clk);
    chk("rst_iq_valid", 32'(bus.IQ_input_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.IC_req_valid), 32'd0);
    chk("rst_req_addr", bus.IC_req_addr, 32'd0);
    chk("rst_iq_inst", bus.IQ_inst, 32'd0);
    chk("rst_iq_pc", bus.IQ_inst_pc, 32'd0);
    chk("rst_iq_pred", bus.IQ_predicted_pc, 32'd0);
    chk("rst_iq_taken", 32'(bus.IQ_predicted_to_jump), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; rdy = 1'b1;

    // Sequential stream with a 1-cycle cache.
    for (int k = 0; k < 3; k++) begin
      wait_push(32'(4 * k), pred, tk, n);
      chk("seq_pred_pc", pred, 32'(4 * k + 4));
      chk("seq_taken", 32'(tk), 32'd0);
      if (k == 1) chk("fetch_period", 32'(n), 32'd3);
    end

    // JAL redirects the stream.
    wait_push(32'h10, pred, tk, n);
    chk("jal_taken", 32'(tk), 32'd1);
    chk("jal_pred_pc", pred, 32'h30);
    wait_req(a);
    chk("jal_next_req", a, 32'h30);

    // Conditional branch trained through the counter table.
    wait_push(32'h40, pred, tk, n);
    chk("beq_cold_taken", 32'(tk), 32'd0);
    chk("beq_cold_pred", pred, 32'h44);
    bht_update(32'h40, 1'b1);
    bht_update(32'h40, 1'b1);
    rollback(32'h40);
    wait_push(32'h40, pred, tk, n);
    chk("beq_trained_taken", 32'(tk), 32'd1);
    chk("beq_trained_pred", pred, 32'h38);
    for (int k = 0; k < 3; k++) bht_update(32'h40, 1'b1);
    bht_update(32'h40, 1'b0);
    repeat (3) @(posedge clk);
    wait_push(32'h40, pred, tk, n);
    chk("beq_saturated_taken", 32'(tk), 32'd1);
    bht_update(32'h40, 1'b0);
    repeat (3) @(posedge clk);
    wait_push(32'h40, pred, tk, n);
    chk("beq_weak_nt_taken", 32'(tk), 32'd0);
    chk("beq_weak_nt_pred", pred, 32'h44);

    // Rollback while a 3-cycle request is outstanding.
    lat = 3;
    wait_req(a);
    rollback(32'h100);
    wait_req(a);
    chk("flush_next_req", a, 32'h100);
    wait_any_push(p);
    chk("flush_first_push", p, 32'h100);

    // Rollback in the same cycle as the response.
    lat = 1;
    wait_req(a);
    @(posedge clk); #1;
    bus.ROB_roll_back_flag = 1'b1;
    bus.ROB_target_pc      = 32'h200;
    @(posedge clk); #1;
    bus.ROB_roll_back_flag = 1'b0;
    @(negedge clk);
    chk("coinc_no_push", 32'(bus.IQ_input_valid), 32'd0);
    chk("coinc_idle_req", 32'(bus.IC_req_valid), 32'd0);
    @(negedge clk);
    chk("coinc_req_valid", 32'(bus.IC_req_valid), 32'd1);
    chk("coinc_req_addr", bus.IC_req_addr, 32'h200);

    // Queue full blocks issue; release issues the following cycle.
    @(posedge clk); #1;
    bus.IQ_is_full = 1'b1;
    for (int i = 0; i < 20 && bus.IC_req_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("full_no_req", 32'(bus.IC_req_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.IQ_is_full = 1'b0;
    @(negedge clk);
    chk("full_release_same", 32'(bus.IC_req_valid), 32'd0);
    @(negedge clk);
    chk("full_release_issue", 32'(bus.IC_req_valid), 32'd1);

    // Freeze in the middle of a request.
    lat = 3;
    wait_req(a);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("frz_req_held", 32'(bus.IC_req_valid), 32'd1);
      chk("frz_no_push", 32'(bus.IQ_input_valid), 32'd0);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_any_push(p);
    chk("frz_resume_push", p, a);

    // Reset while a request is outstanding.
    wait_req(a);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_valid", 32'(bus.IC_req_valid), 32'd0);
    chk("rst_mid_iq_valid", 32'(bus.IQ_input_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_any_push(p);
    chk("rst_mid_restart_pc", p, 32'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
